mem_arbiter: RTL



---
 rtl/arb_types.sv | 23 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/arb_req_reg.sv | 27 ++
 rtl/mem_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/arb_types.sv
// Shared types for the two-port memory arbiter: FSM states, port ids and the
// captured request record.
package arb_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I,
        ARB_D
    } arb_state_t;

    typedef enum logic {
        ARB_PORT_I,
        ARB_PORT_D
    } arb_port_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        is_write;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU-side (ports a/b) and memory-side signals around mem_arbiter.
// slave is the arbiter's view, master is the requester/memory-model view.
interface mem_arbiter_if;
  logic        read_a;
  logic [31:0] address_a;
  logic        resp_a;
  logic [31:0] rdata_a;

  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        resp_b;
  logic [31:0] rdata_b;

  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  modport slave (
    input  read_a, address_a, read_b, write, wmask, address_b, wdata,
           pmem_resp, pmem_rdata,
    output resp_a, rdata_a, resp_b, rdata_b,
           pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata
  );

  modport master (
    output read_a, address_a, read_b, write, wmask, address_b, wdata,
           pmem_resp, pmem_rdata,
    input  resp_a, rdata_a, resp_b, rdata_b,
           pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/arb_req_reg.sv
// Load-enabled holding register for the granted request; it is the sole
// source of the downstream address/data/mask while a transaction is in flight.
module arb_req_reg
  import arb_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  arb_req_t d,
  output arb_req_t q
);

  arb_req_t req_q, req_d;

  always_comb begin
    req_d = req_q;
    if (load) req_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= req_d;
  end

  assign q = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch (a) and data (b) ports onto one memory port,
// one transaction outstanding. Define MEM_ARB_RR_EN for round-robin grant.
module mem_arbiter
  import arb_types::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;
  arb_req_t   req_q, req_new;
  logic       req_b, grant_d, grant_i, load;

  assign req_b = bus.read_b | bus.write;

`ifdef MEM_ARB_RR_EN
  arb_port_t last_q, last_d;

  // Contention goes to whichever port did not win the previous grant.
  always_comb begin
    grant_d = req_b && (!bus.read_a || last_q == ARB_PORT_I);
    grant_i = bus.read_a && !grant_d;
    last_d  = last_q;
    if (state_q == ARB_IDLE && grant_d)      last_d = ARB_PORT_D;
    else if (state_q == ARB_IDLE && grant_i) last_d = ARB_PORT_I;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= ARB_PORT_I;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    grant_d = req_b;
    grant_i = bus.read_a && !req_b;
  end
`endif

  assign load = (state_q == ARB_IDLE) && (grant_d || grant_i);

  // A data request with both read_b and write set is captured as a write.
  always_comb begin
    req_new = '0;
    if (grant_d) begin
      req_new.addr     = bus.address_b;
      req_new.wdata    = bus.wdata;
      req_new.wmask    = bus.wmask;
      req_new.is_write = bus.write;
    end else begin
      req_new.addr     = bus.address_a;
    end
  end

  arb_req_reg u_req_reg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (req_new),
    .q    (req_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d)      state_d = ARB_D;
        else if (grant_i) state_d = ARB_I;
      end
      ARB_I, ARB_D: begin
        if (bus.pmem_resp) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.resp_a       = 1'b0;
    bus.resp_b       = 1'b0;
    bus.pmem_address = req_q.addr;
    bus.pmem_wdata   = req_q.wdata;
    bus.pmem_wmask   = req_q.wmask;
    bus.rdata_a      = bus.pmem_rdata;
    bus.rdata_b      = bus.pmem_rdata;
    if (state_q == ARB_I) begin
      bus.pmem_read = 1'b1;
      bus.resp_a    = bus.pmem_resp;
    end else if (state_q == ARB_D) begin
      bus.pmem_read  = !req_q.is_write;
      bus.pmem_write = req_q.is_write;
      bus.resp_b     = bus.pmem_resp;
    end
  end

endmodule
